// File: rtl/rate_div_pkg.sv
// Shared definitions for the programmable rate divider: FSM states,
// mode encodings and the stock 50 MHz -> 1 Hz terminal count.
package rate_div_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } div_state_t;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int unsigned RATE_1HZ_AT_50MHZ = 49_999_999;

endpackage

// File: rtl/rate_shadow_reg.sv
// Shadow/active rate pair with a load/ack handshake. A loaded rate waits in
// the shadow until the owner signals a safe point through apply.
module rate_shadow_reg
    import rate_div_pkg::*;
#(
    parameter int unsigned WIDTH        = 27,
    parameter int unsigned DEFAULT_RATE = RATE_1HZ_AT_50MHZ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rate_in,
    input  logic             rate_load,
    input  logic             apply,
    output logic [WIDTH-1:0] rate_active,
    output logic             rate_ack
);

    localparam logic [WIDTH-1:0] RESET_RATE = WIDTH'(DEFAULT_RATE);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;

    // Apply is evaluated before capture so a load coinciding with apply
    // promotes the previous shadow and leaves the new value pending.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack_d     = rate_load;
        if (apply && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (rate_load) begin
            shadow_d  = rate_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q  <= RESET_RATE;
            active_q  <= RESET_RATE;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
        end
    end

    assign rate_active = active_q;
    assign rate_ack    = ack_q;

endmodule

// File: rtl/rate_divider_prog.sv
// Programmable rate divider: free-run or one-shot tick generator with
// pause, synchronous clear and glitch-free rate reprogramming.
module rate_divider_prog
    import rate_div_pkg::*;
#(
    parameter int unsigned WIDTH        = 27,
    parameter int unsigned DEFAULT_RATE = RATE_1HZ_AT_50MHZ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] rate_in,
    input  logic             rate_load,
    output logic             rate_ack,
    output logic [WIDTH-1:0] count_out,
    output logic             tick,
    output logic             busy
);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rate_active;
    logic             at_terminal;

    rate_shadow_reg #(
        .WIDTH        (WIDTH),
        .DEFAULT_RATE (DEFAULT_RATE)
    ) u_shadow (
        .clk         (clk),
        .reset       (reset),
        .rate_in     (rate_in),
        .rate_load   (rate_load),
        .apply       ((state_q == ST_IDLE) || tick),
        .rate_active (rate_active),
        .rate_ack    (rate_ack)
    );

    assign at_terminal = (count_q == rate_active);
    assign tick        = (state_q == ST_RUN) && enable && at_terminal;
    assign busy        = (state_q == ST_RUN);
    assign count_out   = count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (enable && ((mode == MODE_FREE) || start)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (at_terminal) begin
                            count_d = '0;
                            if (mode == MODE_ONESHOT) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rate_divider_prog.sv
// Scenario bench for rate_divider_prog at WIDTH=4, DEFAULT_RATE=3 using
// hand-derived per-cycle expectation tables fed through a scoreboard queue.
module tb_rate_divider_prog;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       mode;
    logic       start;
    logic       clear;
    logic [3:0] rate_in;
    logic       rate_load;
    logic       rate_ack;
    logic [3:0] count_out;
    logic       tick;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       en;
        logic       md;
        logic       st;
        logic       cl;
        logic       ld;
        logic [3:0] rin;
    } stim_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tk;
        logic       bz;
        logic       ak;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } step_t;

    step_t plan_q[$];
    exp_t  sb_q[$];

    rate_divider_prog #(
        .WIDTH        (4),
        .DEFAULT_RATE (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .start     (start),
        .clear     (clear),
        .rate_in   (rate_in),
        .rate_load (rate_load),
        .rate_ack  (rate_ack),
        .count_out (count_out),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic stim_t S(input bit en, input bit md, input bit st,
                                input bit cl, input bit ld, input int rin);
        stim_t r;
        r.en  = en;
        r.md  = md;
        r.st  = st;
        r.cl  = cl;
        r.ld  = ld;
        r.rin = 4'(rin);
        return r;
    endfunction

    function automatic exp_t E(input int cnt, input bit tk, input bit bz, input bit ak);
        exp_t r;
        r.cnt = 4'(cnt);
        r.tk  = tk;
        r.bz  = bz;
        r.ak  = ak;
        return r;
    endfunction

    function automatic exp_t observe();
        exp_t r;
        r.cnt = count_out;
        r.tk  = tick;
        r.bz  = busy;
        r.ak  = rate_ack;
        return r;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("cnt=%0d tick=%b busy=%b ack=%b", v.cnt, v.tk, v.bz, v.ak);
    endfunction

    task automatic drive(input stim_t s);
        enable    = s.en;
        mode      = s.md;
        start     = s.st;
        clear     = s.cl;
        rate_load = s.ld;
        rate_in   = s.rin;
    endtask

    task automatic add(input stim_t s, input exp_t e);
        step_t p;
        p.s = s;
        p.e = e;
        plan_q.push_back(p);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(S(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t o;
        drive(S(1, 0, 1, 0, 1, 9));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = observe();
            n_cmp++;
            if (o !== E(0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL reset cyc=%0d got %s expected %s", i, fmt(o), fmt(E(0, 0, 0, 0)));
            end
        end
    endtask

    task automatic test_free_run();
        step_t p;
        exp_t  e, o;
        int    cyc = 0;
        do_reset();
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        for (int i = 0; i < 8; i++) add(S(1, 0, 0, 0, 0, 0), E(i % 4, (i % 4) == 3, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL free_run cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rate_update();
        step_t p;
        exp_t  e, o;
        int    cyc = 0;
        do_reset();
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        add(S(1, 0, 0, 0, 1, 5), E(1, 0, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(2, 0, 1, 1));
        add(S(1, 0, 0, 0, 0, 0), E(3, 1, 1, 0));
        for (int i = 0; i < 6; i++) add(S(1, 0, 0, 0, 0, 0), E(i, i == 5, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rate_update cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_one_shot();
        step_t p;
        exp_t  e, o;
        int    cyc = 0;
        do_reset();
        add(S(0, 1, 0, 0, 1, 2), E(0, 0, 0, 0));
        add(S(0, 1, 0, 0, 0, 0), E(0, 0, 0, 1));
        add(S(1, 1, 0, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 1, 1, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 1, 0, 0, 0, 0), E(0, 0, 1, 0));
        add(S(1, 1, 1, 0, 0, 0), E(1, 0, 1, 0));
        add(S(1, 1, 0, 0, 0, 0), E(2, 1, 1, 0));
        add(S(1, 1, 0, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 1, 0, 0, 0, 0), E(0, 0, 0, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL one_shot cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_pause();
        step_t p;
        exp_t  e, o;
        int    cyc = 0;
        do_reset();
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(1, 0, 1, 0));
        for (int i = 0; i < 5; i++) add(S(0, 0, 0, 0, 0, 0), E(2, 0, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(2, 0, 1, 0));
        add(S(0, 0, 0, 0, 0, 0), E(3, 0, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(3, 1, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pause cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    // Rate 0 makes every RUN cycle terminal, so loads here also land on a terminal edge.
    task automatic test_rate_zero();
        step_t p;
        exp_t  e, o;
        int    cyc = 0;
        do_reset();
        add(S(0, 0, 0, 0, 1, 0), E(0, 0, 0, 0));
        add(S(0, 0, 0, 0, 0, 0), E(0, 0, 0, 1));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 1, 1, 0));
        add(S(1, 0, 0, 0, 1, 5), E(0, 1, 1, 0));
        add(S(1, 0, 0, 0, 1, 1), E(0, 1, 1, 1));
        for (int i = 0; i < 6; i++) add(S(1, 0, 0, 0, 0, 0), E(i, i == 5, 1, i == 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(1, 1, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rate_zero cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back_load();
        step_t p;
        exp_t  e, o;
        int    cyc = 0;
        do_reset();
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        add(S(1, 0, 0, 0, 1, 7), E(1, 0, 1, 0));
        add(S(1, 0, 0, 0, 1, 9), E(2, 0, 1, 1));
        add(S(1, 0, 0, 0, 0, 0), E(3, 1, 1, 1));
        for (int i = 0; i < 10; i++) add(S(1, 0, 0, 0, 0, 0), E(i, i == 9, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL back_to_back cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_clear();
        step_t p;
        exp_t  e, o;
        int    cyc = 0;
        do_reset();
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        add(S(1, 0, 0, 0, 1, 6), E(1, 0, 1, 0));
        add(S(1, 0, 1, 1, 0, 0), E(2, 0, 1, 1));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        for (int i = 0; i < 7; i++) add(S(1, 0, 0, 0, 0, 0), E(i, i == 6, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL clear cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_async_reset();
        step_t p;
        exp_t  e, o;
        int    cyc = 0;
        do_reset();
        add(S(0, 0, 0, 0, 1, 7), E(0, 0, 0, 0));
        add(S(0, 0, 0, 0, 0, 0), E(0, 0, 0, 1));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(1, 0, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(2, 0, 1, 0));
        add(S(1, 0, 0, 0, 1, 2), E(3, 0, 1, 0));
        add(S(1, 0, 0, 0, 0, 0), E(4, 0, 1, 1));
        add(S(1, 0, 0, 0, 0, 0), E(5, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL async_reset_pre cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            if (plan_q.size() > 0) begin
                @(posedge clk);
                #1;
            end
        end
        // Mid-cycle, away from any clock edge, with rate 2 still pending.
        #2;
        reset = 1'b0;
        #1;
        o = observe();
        n_cmp++;
        if (o !== E(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL async_reset_assert got %s expected %s", fmt(o), fmt(E(0, 0, 0, 0)));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        add(S(1, 0, 0, 0, 0, 0), E(0, 0, 0, 0));
        for (int i = 0; i < 5; i++) add(S(1, 0, 0, 0, 0, 0), E(i % 4, (i % 4) == 3, 1, 0));
        cyc = 0;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s);
            sb_q.push_back(p.e);
            @(negedge clk);
            e = sb_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL async_reset_post cyc=%0d got %s expected %s", cyc, fmt(o), fmt(e));
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(S(0, 0, 0, 0, 0, 0));
        test_reset();
        test_free_run();
        test_rate_update();
        test_one_shot();
        test_pause();
        test_rate_zero();
        test_back_to_back_load();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
